// File: rtl/mor1kx_ibus_refill_wb_pkg.sv
// Shared Wishbone B3 cycle/burst codes and refill FSM encodings for the icache bus bridge.
package mor1kx_ibus_refill_wb_pkg;

  localparam logic [2:0] CtiClassic = 3'b000;
  localparam logic [2:0] CtiIncr    = 3'b010;
  localparam logic [2:0] CtiEnd     = 3'b111;

  localparam logic [1:0] BteLinear  = 2'b00;
  localparam logic [1:0] BteWrap4   = 2'b01;
  localparam logic [1:0] BteWrap8   = 2'b10;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StBurst    = 2'd1;
  localparam logic [1:0] StSingle   = 2'd2;
  localparam logic [1:0] StRetry    = 2'd3;

  function automatic logic [1:0] burst_bte(input int unsigned len);
    return (len == 4) ? BteWrap4 : BteWrap8;
  endfunction

endpackage

// File: rtl/mor1kx_ibus_refill_wb_if.sv
// Wishbone B3 bus between the icache refill master and the memory slave.
interface mor1kx_ibus_refill_wb_if #(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32
);
  logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o;
  logic                            wbm_cyc_o;
  logic                            wbm_stb_o;
  logic                            wbm_we_o;
  logic [3:0]                      wbm_sel_o;
  logic [2:0]                      wbm_cti_o;
  logic [1:0]                      wbm_bte_o;
  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_o;
  logic                            wbm_ack_i;
  logic                            wbm_err_i;
  logic                            wbm_rty_i;
  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i;

  modport master (
    output wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_cti_o, wbm_bte_o,
           wbm_dat_o,
    input  wbm_ack_i, wbm_err_i, wbm_rty_i, wbm_dat_i
  );

  modport slave (
    input  wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_cti_o, wbm_bte_o,
           wbm_dat_o,
    output wbm_ack_i, wbm_err_i, wbm_rty_i, wbm_dat_i
  );
endinterface

// File: rtl/mor1kx_ibus_refill_wb.sv
// Instruction-bus Wishbone master: single fetches and wrapping cache-line refill bursts,
// with error abort, retry reissue and request withdrawal.
module mor1kx_ibus_refill_wb
  import mor1kx_ibus_refill_wb_pkg::*;
#(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned BURST_LENGTH         = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cpu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] cpu_adr_i,
  input  logic                            cpu_burst_i,
  output logic                            cpu_ack_o,
  output logic                            cpu_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] cpu_dat_o,
  mor1kx_ibus_refill_wb_if.master         wbm
);

  localparam int unsigned CntW = $clog2(BURST_LENGTH);
  localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LENGTH - 1);
  // Byte-offset bits covered by one aligned refill block.
  localparam logic [OPTION_OPERAND_WIDTH-1:0] WrapMask =
    OPTION_OPERAND_WIDTH'(BURST_LENGTH * 4 - 1);

  logic [1:0]                      r_state, w_state;
  logic [OPTION_OPERAND_WIDTH-1:0] r_adr, w_adr;
  logic                            r_cyc, w_cyc;
  logic                            r_stb, w_stb;
  logic [2:0]                      r_cti, w_cti;
  logic [1:0]                      r_bte, w_bte;
  logic [CntW-1:0]                 r_cnt, w_cnt;

  logic [OPTION_OPERAND_WIDTH-1:0] w_adr_wrap;
  logic [CntW-1:0]                 w_cnt_inc;
  logic                            w_err;
  logic                            w_unused_adr_lsb;

  assign w_unused_adr_lsb = ^cpu_adr_i[1:0];

  assign w_adr_wrap = (r_adr & ~WrapMask) | ((r_adr + OPTION_OPERAND_WIDTH'(4)) & WrapMask);
  assign w_cnt_inc  = r_cnt + CntW'(1);
  assign w_err      = wbm.wbm_err_i & r_cyc;

  always_comb begin
    w_state = r_state;
    w_adr   = r_adr;
    w_cyc   = r_cyc;
    w_stb   = r_stb;
    w_cti   = r_cti;
    w_bte   = r_bte;
    w_cnt   = r_cnt;

    unique case (r_state)
      StIdle: begin
        if (cpu_req_i) begin
          w_cyc = 1'b1;
          w_stb = 1'b1;
          w_adr = {cpu_adr_i[OPTION_OPERAND_WIDTH-1:2], 2'b00};
          w_cnt = '0;
          if (cpu_burst_i) begin
            w_state = StBurst;
            w_cti   = CtiIncr;
            w_bte   = burst_bte(BURST_LENGTH);
          end else begin
            w_state = StSingle;
            w_cti   = CtiClassic;
            w_bte   = BteLinear;
          end
        end
      end

      StBurst, StSingle, StRetry: begin
        if (!cpu_req_i || w_err) begin
          w_state = StIdle;
          w_cyc   = 1'b0;
          w_stb   = 1'b0;
          w_cti   = CtiClassic;
          w_bte   = BteLinear;
          w_cnt   = '0;
        end else if (r_state == StRetry) begin
          // Reissue the held address/cti; bte tells which beat type was interrupted.
          w_stb   = 1'b1;
          w_state = (r_bte != BteLinear) ? StBurst : StSingle;
        end else if (wbm.wbm_ack_i) begin
          if (r_state == StSingle || r_cnt == LastBeat) begin
            w_state = StIdle;
            w_cyc   = 1'b0;
            w_stb   = 1'b0;
            w_cti   = CtiClassic;
            w_bte   = BteLinear;
            w_cnt   = '0;
          end else begin
            w_adr = w_adr_wrap;
            w_cnt = w_cnt_inc;
            w_cti = (w_cnt_inc == LastBeat) ? CtiEnd : CtiIncr;
          end
        end else if (wbm.wbm_rty_i) begin
          w_stb   = 1'b0;
          w_state = StRetry;
        end
      end

      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_adr   <= '0;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_cti   <= CtiClassic;
      r_bte   <= BteLinear;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_adr   <= w_adr;
      r_cyc   <= w_cyc;
      r_stb   <= w_stb;
      r_cti   <= w_cti;
      r_bte   <= w_bte;
      r_cnt   <= w_cnt;
    end
  end

  assign wbm.wbm_adr_o = r_adr;
  assign wbm.wbm_cyc_o = r_cyc;
  assign wbm.wbm_stb_o = r_stb;
  assign wbm.wbm_cti_o = r_cti;
  assign wbm.wbm_bte_o = r_bte;
  assign wbm.wbm_we_o  = 1'b0;
  assign wbm.wbm_sel_o = 4'hf;
  assign wbm.wbm_dat_o = '0;

  // Error beats never also count as data beats.
  assign cpu_ack_o = wbm.wbm_ack_i & r_cyc & r_stb & ~wbm.wbm_err_i;
  assign cpu_err_o = w_err;
  assign cpu_dat_o = wbm.wbm_dat_i;

endmodule

// File: doc/mor1kx_ibus_refill_wb.md
MOR1KX_IBUS_REFILL_WB -- requirements
Module: mor1kx_ibus_refill_wb

Interface
REQ-001 SHALL have parameter OPTION_OPERAND_WIDTH, default 32: data/address width.
REQ-002 SHALL have parameter BURST_LENGTH, default 8: words per refill burst; legal values are 4 and 8.
REQ-003 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port cpu_req_i, input, 1: icache fetch/refill request, held until done.
REQ-006 SHALL have port cpu_adr_i, input, 32: byte address of the first word.
REQ-007 SHALL have port cpu_burst_i, input, 1: 1 = refill burst of BURST_LENGTH words; 0 = single word.
REQ-008 SHALL have port cpu_ack_o, output, 1: a data word is valid this cycle.
REQ-009 SHALL have port cpu_err_o, output, 1: bus error on the current beat.
REQ-010 SHALL have port cpu_dat_o, output, 32: returned instruction word.
REQ-011 SHALL have Wishbone B3 master outputs: wbm_adr_o (32), wbm_cyc_o (1), wbm_stb_o (1), wbm_we_o (1), wbm_sel_o (4), wbm_cti_o (3), wbm_bte_o (2), wbm_dat_o (32).
REQ-012 SHALL have Wishbone B3 master inputs: wbm_ack_i (1), wbm_err_i (1), wbm_rty_i (1), wbm_dat_i (32).

Function
REQ-013 SHALL register all wbm_* outputs; wbm_we_o=0, wbm_sel_o=4'hf and wbm_dat_o=0 at all times.
REQ-014 SHALL implement states IDLE, BURST, SINGLE and RETRY.
REQ-015 IDLE: on cpu_req_i=1, SHALL set cyc=stb=1 and adr={cpu_adr_i[31:2],2'b00} next cycle, entering BURST if cpu_burst_i=1 or SINGLE if 0; first-beat latency is 1 cycle.
REQ-016 BURST: SHALL drive cti=3'b010 and bte=2'b01 (4-beat wrap) or 2'b10 (8-beat wrap) from BURST_LENGTH.
REQ-017 BURST: on each wbm_ack_i, SHALL advance the word address within the aligned block (offset+1 mod BURST_LENGTH, upper bits unchanged) and increment the beat counter (width log2(BURST_LENGTH)).
REQ-018 BURST: SHALL drive cti=3'b111 on the final beat (counter = BURST_LENGTH-1); on its ack, SHALL drop cyc/stb next cycle and return to IDLE.
REQ-019 SINGLE: SHALL drive cti=3'b000 and bte=2'b00; on ack, SHALL drop cyc/stb and return to IDLE.
REQ-020 SHALL assign cpu_ack_o = wbm_ack_i & wbm_cyc_o & wbm_stb_o combinationally and cpu_dat_o = wbm_dat_i (zero added latency).
REQ-021 SHALL assign cpu_err_o = wbm_err_i & wbm_cyc_o; on err, SHALL drop cyc/stb next cycle, discard remaining beats and enter IDLE.
REQ-022 If wbm_err_i and wbm_ack_i coincide, err SHALL win: no cpu_ack_o.
REQ-023 wbm_rty_i (without ack/err) SHALL drop stb for one cycle (RETRY, cyc kept high), then reissue the same address and cti, beat counter unchanged.
REQ-024 Withdrawal: if cpu_req_i=0 in BURST/SINGLE/RETRY, SHALL drop cyc/stb next cycle, ignore any ack in that cycle for the counter, and return to IDLE.
REQ-025 A new cpu_req_i SHALL NOT be accepted until at least one cycle in IDLE with cyc=0 (no back-to-back cycles).
REQ-026 A burst SHALL start at any word offset and wrap; e.g. base 0x104 with BURST_LENGTH 8 yields 0x104..0x11C, 0x100.

Reset
REQ-027 On rst, SHALL enter IDLE with cyc=stb=0, adr=0, cti=3'b000, bte=2'b00 and beat counter 0.
REQ-028 cpu_ack_o and cpu_err_o SHALL be 0 during and the cycle after rst, since cyc=0.
REQ-029 Reset mid-burst SHALL abandon the cycle with no further outputs.

Structure
REQ-030 The CTI codes (classic 000, incrementing 010, end 111) and BTE codes (linear 00, wrap4 01, wrap8 10) SHALL live in the shared mor1kx-defines constants file.
REQ-031 No sub-module is required; wrap-address and counter logic SHALL be implemented inline.

Verification
REQ-032 Burst, BURST_LENGTH=8, cpu_adr_i=0x2008, slave acks every cycle -> addresses 0x2008,0x200C..0x201C,0x2000,0x2004; cti=010 for beats 0-6 and 111 for beat 7; 8 cpu_ack_o; cyc low one cycle after the last ack.
REQ-033 Single, cpu_burst_i=0, adr 0x40 -> one beat with cti=000, bte=00; cpu_dat_o equals wbm_dat_i in the ack cycle.
REQ-034 Error: wbm_err_i on beat 3 of an 8-beat burst -> cpu_err_o=1 that cycle, cyc=0 next cycle, state IDLE, 3 acks total.
REQ-035 Retry: wbm_rty_i on beat 2 (adr 0x1008) -> stb low 1 cycle, cyc stays high, 0x1008 reissued, burst completes with 8 acks.
REQ-036 Withdrawal: cpu_req_i dropped after beat 4 -> cyc=stb=0 next cycle; a new request 2 cycles later starts cleanly with counter 0.
REQ-037 Reset: rst asserted mid-burst with ack pending -> next cycle cyc=0, cti=000, adr=0, no cpu_ack_o.
